// File: rtl/uart_prog_loader_pkg.sv
// Shared definitions for the UART program loader: command byte codes,
// memory select values, FSM state encodings and the baud divisor helper.
package uart_prog_loader_pkg;

    localparam logic [7:0] LD_CMD_I = 8'h49;
    localparam logic [7:0] LD_CMD_D = 8'h44;
    localparam logic [7:0] LD_CMD_E = 8'h45;

    localparam logic LD_SEL_IMEM = 1'b0;
    localparam logic LD_SEL_DMEM = 1'b1;

    typedef enum logic [2:0] {
        LD_IDLE = 3'd0,
        LD_LEN0 = 3'd1,
        LD_LEN1 = 3'd2,
        LD_DATA = 3'd3,
        LD_DONE = 3'd4
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_HUNT  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Oversample tick divisor, truncated, never below 1.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned os);
        int unsigned d;
        d = clk_hz / (baud * os);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_prog_loader_rx_byte.sv
// 8N1 UART receiver: 2-FF synchroniser, oversample tick down-counter and a
// bit-level FSM. Delivers one-cycle byte_valid/frame_err pulses.
//
// state    | meaning
// ---------+----------------------------------------------------------
// RX_HUNT  | line idle, waiting for a falling edge
// RX_START | falling edge seen, confirming start bit low at mid-bit
// RX_DATA  | sampling 8 data bits LSB first, one per OVERSAMPLE ticks
// RX_STOP  | sampling stop bit; high -> byte_valid, low -> frame_err
module uart_rx_byte
    import uart_prog_loader_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       raw_clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int unsigned DIV  = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [15:0]     DIV_RELOAD = 16'(DIV - 1);
    localparam logic [OS_W-1:0] OS_HALF    = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_FULL    = OS_W'(OVERSAMPLE - 1);

    rx_state_t       rx_state, rx_next;
    logic [1:0]      sync_q;
    logic            prev_q;
    logic [15:0]     div_cnt;
    logic [OS_W-1:0] os_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;

    logic rx_s;
    logic fall;
    logic tick;
    logic half_hit;
    logic full_hit;

    assign rx_s     = sync_q[1];
    assign fall     = prev_q & ~rx_s;
    assign tick     = (div_cnt == 16'd0);
    assign half_hit = tick && (os_cnt == OS_HALF);
    assign full_hit = tick && (os_cnt == OS_FULL);

    // Bit FSM state register.
    always_ff @(posedge raw_clk) begin
        if (rst) rx_state <= RX_HUNT;
        else     rx_state <= rx_next;
    end

    // Bit FSM next-state: a start bit that is high again at mid-bit is a glitch.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_HUNT:  if (fall) rx_next = RX_START;
            RX_START: if (half_hit) rx_next = rx_s ? RX_HUNT : RX_DATA;
            RX_DATA:  if (full_hit && (bit_cnt == 3'd7)) rx_next = RX_STOP;
            RX_STOP:  if (full_hit) rx_next = RX_HUNT;
            default:  rx_next = RX_HUNT;
        endcase
    end

    // Synchroniser, tick divider, sample counters, shift register and output pulses.
    always_ff @(posedge raw_clk) begin
        if (rst) begin
            sync_q     <= 2'b11;
            prev_q     <= 1'b1;
            div_cnt    <= '0;
            os_cnt     <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            sync_q     <= {sync_q[0], rx_i};
            prev_q     <= rx_s;
            div_cnt    <= tick ? DIV_RELOAD : div_cnt - 16'd1;
            case (rx_state)
                RX_HUNT: begin
                    os_cnt  <= '0;
                    bit_cnt <= '0;
                end
                RX_START: begin
                    if (tick) os_cnt <= half_hit ? '0 : os_cnt + OS_W'(1);
                end
                RX_DATA: begin
                    if (full_hit) begin
                        os_cnt  <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end else if (tick) begin
                        os_cnt <= os_cnt + OS_W'(1);
                    end
                end
                RX_STOP: begin
                    if (full_hit) begin
                        os_cnt <= '0;
                        if (rx_s) begin
                            rx_byte    <= shreg;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else if (tick) begin
                        os_cnt <= os_cnt + OS_W'(1);
                    end
                end
                default: os_cnt <= '0;
            endcase
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// UART boot loader: parses I/D/E framed program images from the receiver
// and emits word writes into instruction or data memory.
//
// state   | meaning
// --------+-------------------------------------------------------------
// LD_IDLE | waiting for a command byte ('I', 'D', 'E'; others ignored)
// LD_LEN0 | expecting word count low byte
// LD_LEN1 | expecting word count high byte; zero count returns to idle
// LD_DATA | assembling 4-byte little-endian words, one write per word
// LD_DONE | end command seen; absorbs all bytes until reset
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned WORD_AW    = 14
) (
    input  logic               raw_clk,
    input  logic               rst,
    input  logic               arm_i,
    input  logic               rx_i,
    output logic               upg_wen_o,
    output logic [WORD_AW:0]   upg_adr_o,
    output logic [31:0]        upg_dat_o,
    output logic               upg_done_o,
    output logic               busy_o,
    output logic               err_o
);

    localparam int unsigned IDX_LIM = 2 ** WORD_AW;

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_err;
    logic       byte_ok;

    ld_state_t  state_q, state_d;
    logic       sel_q;
    logic [15:0] cnt_q;
    logic [15:0] idx_q;
    logic [1:0]  bidx_q;
    logic [23:0] asm_q;

    logic [15:0] idx_inc;
    logic [15:0] len_full;
    logic        idx_ovf;
    logic        is_cmd_id;

    uart_rx_byte #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_rx (
        .raw_clk    (raw_clk),
        .rst        (rst),
        .rx_i       (rx_i),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    // While disarmed the receiver keeps tracking the line but the frame FSM is frozen.
    assign byte_ok   = byte_valid & arm_i;
    assign idx_inc   = idx_q + 16'd1;
    assign len_full  = {rx_byte, cnt_q[7:0]};
    assign idx_ovf   = 32'(idx_q) >= IDX_LIM;
    assign is_cmd_id = (rx_byte == LD_CMD_I) || (rx_byte == LD_CMD_D);
    assign busy_o    = (state_q == LD_LEN0) || (state_q == LD_LEN1) || (state_q == LD_DATA);

    // Frame FSM state register.
    always_ff @(posedge raw_clk) begin
        if (rst) state_q <= LD_IDLE;
        else     state_q <= state_d;
    end

    // Frame FSM next-state, advanced only by accepted bytes.
    always_comb begin
        state_d = state_q;
        if (byte_ok) begin
            case (state_q)
                LD_IDLE: begin
                    if (is_cmd_id)                 state_d = LD_LEN0;
                    else if (rx_byte == LD_CMD_E)  state_d = LD_DONE;
                end
                LD_LEN0: state_d = LD_LEN1;
                LD_LEN1: state_d = (len_full == 16'd0) ? LD_IDLE : LD_DATA;
                LD_DATA: if ((bidx_q == 2'd3) && (idx_inc == cnt_q)) state_d = LD_IDLE;
                LD_DONE: state_d = LD_DONE;
                default: state_d = LD_IDLE;
            endcase
        end
    end

    // Count capture, word assembly, write strobe and sticky flags.
    always_ff @(posedge raw_clk) begin
        if (rst) begin
            sel_q      <= LD_SEL_IMEM;
            cnt_q      <= '0;
            idx_q      <= '0;
            bidx_q     <= '0;
            asm_q      <= '0;
            upg_wen_o  <= 1'b0;
            upg_adr_o  <= '0;
            upg_dat_o  <= '0;
            upg_done_o <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            upg_wen_o <= 1'b0;
            if (frame_err) err_o <= 1'b1;
            if (byte_ok) begin
                case (state_q)
                    LD_IDLE: begin
                        if (is_cmd_id)
                            sel_q <= (rx_byte == LD_CMD_D) ? LD_SEL_DMEM : LD_SEL_IMEM;
                        if (rx_byte == LD_CMD_E) upg_done_o <= 1'b1;
                    end
                    LD_LEN0: cnt_q[7:0] <= rx_byte;
                    LD_LEN1: begin
                        cnt_q[15:8] <= rx_byte;
                        idx_q       <= '0;
                        bidx_q      <= '0;
                    end
                    LD_DATA: begin
                        bidx_q <= bidx_q + 2'd1;
                        if (bidx_q == 2'd3) begin
                            // Overflowing words are still counted so the frame stays in step.
                            idx_q <= idx_inc;
                            if (idx_ovf) begin
                                err_o <= 1'b1;
                            end else begin
                                upg_wen_o <= 1'b1;
                                upg_adr_o <= {sel_q, idx_q[WORD_AW-1:0]};
                                upg_dat_o <= {rx_byte, asm_q};
                            end
                        end else begin
                            asm_q <= {rx_byte, asm_q[23:8]};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: serialises 8N1 frames at
// 16 cycles/bit and scoreboards every write strobe against expected words.
module tb_uart_prog_loader;

    logic        raw_clk = 1'b0;
    logic        rst     = 1'b1;
    logic        arm_i   = 1'b0;
    logic        rx_i    = 1'b1;
    logic        upg_wen_o;
    logic [14:0] upg_adr_o;
    logic [31:0] upg_dat_o;
    logic        upg_done_o;
    logic        busy_o;
    logic        err_o;

    typedef struct packed {
        logic [14:0] adr;
        logic [31:0] dat;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    always #5 raw_clk = ~raw_clk;

    uart_prog_loader #(
        .CLK_HZ     (1_600_000),
        .BAUD       (100_000),
        .OVERSAMPLE (16),
        .WORD_AW    (14)
    ) u_dut (
        .raw_clk    (raw_clk),
        .rst        (rst),
        .arm_i      (arm_i),
        .rx_i       (rx_i),
        .upg_wen_o  (upg_wen_o),
        .upg_adr_o  (upg_adr_o),
        .upg_dat_o  (upg_dat_o),
        .upg_done_o (upg_done_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    // Advance one cycle; any write strobe is popped from the scoreboard and compared.
    task automatic step_cycle();
        wr_t e;
        @(negedge raw_clk);
        if (upg_wen_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write adr=%h dat=%h, required no write", upg_adr_o, upg_dat_o);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (upg_adr_o !== e.adr) begin
                    errors++;
                    $display("FAIL write_adr got %h expected %h", upg_adr_o, e.adr);
                end
                checks++;
                if (upg_dat_o !== e.dat) begin
                    errors++;
                    $display("FAIL write_dat got %h expected %h", upg_dat_o, e.dat);
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx_i = 1'b0;
        repeat (16) step_cycle();
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (16) step_cycle();
        end
        rx_i = stop_bit;
        repeat (16) step_cycle();
        rx_i = 1'b1;
        repeat (4) step_cycle();
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [15:0] n);
        send_byte(cmd, 1'b1);
        send_byte(n[7:0], 1'b1);
        send_byte(n[15:8], 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        arm_i = 1'b1;
        rx_i  = 1'b1;
        repeat (4) step_cycle();
        checks++;
        if ({upg_wen_o, upg_adr_o, upg_dat_o} !== 48'd0) begin
            errors++;
            $display("FAIL reset_write_outputs got %h expected 0", {upg_wen_o, upg_adr_o, upg_dat_o});
        end
        checks++;
        if ({upg_done_o, busy_o, err_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b expected 000", {upg_done_o, busy_o, err_o});
        end
        rst = 1'b0;
        repeat (2) step_cycle();
        exp_q.delete();
    endtask

    task automatic test_imem_two_words();
        exp_q.push_back('{adr: 15'h0000, dat: 32'h0000_0013});
        exp_q.push_back('{adr: 15'h0001, dat: 32'h0010_0093});
        send_hdr(8'h49, 16'd2);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL imem_busy_after_hdr got %b expected 1", busy_o);
        end
        send_word(32'h0000_0013);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL imem_busy_mid got %b expected 1", busy_o);
        end
        send_word(32'h0010_0093);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL imem_busy_end got %b expected 0", busy_o);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL imem_missing_writes got %0d pending expected 0", exp_q.size());
        end
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL imem_err got %b expected 0", err_o);
        end
    endtask

    task automatic test_ignored_cmd();
        send_byte(8'h5A, 1'b1);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL ignored_cmd_busy got %b expected 0", busy_o);
        end
        send_byte(8'h49, 1'b1);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL zero_len_busy_len0 got %b expected 1", busy_o);
        end
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_busy_end got %b expected 0", busy_o);
        end
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL ignored_cmd_err got %b expected 0", err_o);
        end
    endtask

    task automatic test_arm_gate();
        arm_i = 1'b0;
        send_hdr(8'h49, 16'd1);
        send_word(32'h4433_2211);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL disarmed_busy got %b expected 0", busy_o);
        end
        arm_i = 1'b1;
        exp_q.push_back('{adr: 15'h0000, dat: 32'h4433_2211});
        send_hdr(8'h49, 16'd1);
        send_word(32'h4433_2211);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL armed_missing_write got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_rst_mid_frame();
        send_hdr(8'h49, 16'd1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        rst = 1'b1;
        repeat (2) step_cycle();
        checks++;
        if ({upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, busy_o, err_o} !== 51'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs got %h expected 0",
                     {upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, busy_o, err_o});
        end
        rst = 1'b0;
        repeat (2) step_cycle();
        exp_q.push_back('{adr: 15'h0000, dat: 32'hCAFE_F00D});
        send_hdr(8'h49, 16'd1);
        send_word(32'hCAFE_F00D);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_reload_missing got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_frame_err();
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_pre got %b expected 0", err_o);
        end
        exp_q.push_back('{adr: 15'h4000, dat: 32'h8765_4321});
        send_hdr(8'h44, 16'd1);
        send_byte(8'hFF, 1'b0);
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL frame_err_flag got %b expected 1", err_o);
        end
        send_word(32'h8765_4321);
        checks++;
        if (exp_q.size() != 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_word pending=%0d busy=%b expected 0 and 0", exp_q.size(), busy_o);
        end
    endtask

    task automatic test_dmem_end();
        exp_q.push_back('{adr: 15'h4000, dat: 32'hDEAD_BEEF});
        send_hdr(8'h44, 16'd1);
        send_word(32'hDEAD_BEEF);
        checks++;
        if (upg_done_o !== 1'b0) begin
            errors++;
            $display("FAIL done_before_e got %b expected 0", upg_done_o);
        end
        send_byte(8'h45, 1'b1);
        checks++;
        if (upg_done_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL done_after_e done=%b busy=%b expected 1 and 0", upg_done_o, busy_o);
        end
        send_hdr(8'h49, 16'd1);
        send_word(32'h1234_5678);
        checks++;
        if (upg_done_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL done_absorbing done=%b busy=%b expected 1 and 0", upg_done_o, busy_o);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL dmem_missing_write got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_imem_two_words();
        test_ignored_cmd();
        test_arm_gate();
        test_rst_mid_frame();
        test_frame_err();
        test_reset();
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared_by_rst got %b expected 0", err_o);
        end
        test_dmem_end();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
